// File: rtl/decode_stage.sv
// decode_stage: registered RISC-V instruction decode with a 2-entry skid
// buffer. Decode happens on the input side, so both buffer entries hold a
// fully decoded bundle and every out_* port comes straight from a flop.
module decode_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [6:0]      out_opcode,
    output logic [4:0]      out_rd,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [2:0]      out_func3,
    output logic [6:0]      out_func7,
    output logic [2:0]      out_fmt,
    output logic [XLEN-1:0] out_imm,
    output logic            out_illegal
);

    localparam logic [2:0] FMT_R    = 3'd0;
    localparam logic [2:0] FMT_I    = 3'd1;
    localparam logic [2:0] FMT_S    = 3'd2;
    localparam logic [2:0] FMT_B    = 3'd3;
    localparam logic [2:0] FMT_U    = 3'd4;
    localparam logic [2:0] FMT_J    = 3'd5;
    localparam logic [2:0] FMT_NONE = 3'd7;

    localparam bit IS_RV64 = (XLEN == 64);

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [6:0]      opcode;
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [2:0]      func3;
        logic [6:0]      func7;
        logic [2:0]      fmt;
        logic [XLEN-1:0] imm;
        logic            illegal;
    } bundle_t;

    bundle_t         dec;
    bundle_t         main_q, main_d;
    bundle_t         skid_q, skid_d;
    logic            main_full_q, main_full_d;
    logic            skid_full_q, skid_full_d;
    logic            push, pop;
    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;

    // Each immediate is assembled at its natural width and sign-extended by
    // the signed size cast, so one expression serves both RV32 and RV64.
    assign imm_i = XLEN'($signed(in_instr[31:20]));
    assign imm_s = XLEN'($signed({in_instr[31:25], in_instr[11:7]}));
    assign imm_b = XLEN'($signed({in_instr[31], in_instr[7], in_instr[30:25],
                                  in_instr[11:8], 1'b0}));
    assign imm_u = XLEN'($signed({in_instr[31:12], 12'b0}));
    assign imm_j = XLEN'($signed({in_instr[31], in_instr[19:12], in_instr[20],
                                  in_instr[30:21], 1'b0}));

    // Combinational decode of the incoming instruction into a bundle.
    always_comb begin
        dec         = '0;
        dec.pc      = in_pc;
        dec.opcode  = in_instr[6:0];
        dec.rd      = in_instr[11:7];
        dec.rs1     = in_instr[19:15];
        dec.rs2     = in_instr[24:20];
        dec.func3   = in_instr[14:12];
        dec.func7   = in_instr[31:25];
        dec.fmt     = FMT_NONE;
        dec.imm     = '0;
        dec.illegal = 1'b0;
        // Every listed opcode ends in 2'b11, so matching the full opcode also
        // rejects compressed encodings.
        case (in_instr[6:0])
            7'b0110011:                         dec.fmt = FMT_R;
            7'b0010011, 7'b0000011, 7'b1100111,
            7'b1110011, 7'b0001111:             dec.fmt = FMT_I;
            7'b0100011:                         dec.fmt = FMT_S;
            7'b1100011:                         dec.fmt = FMT_B;
            7'b0110111, 7'b0010111:             dec.fmt = FMT_U;
            7'b1101111:                         dec.fmt = FMT_J;
            7'b0011011: if (IS_RV64)            dec.fmt = FMT_I;
            7'b0111011: if (IS_RV64)            dec.fmt = FMT_R;
            default:                            dec.fmt = FMT_NONE;
        endcase
        case (dec.fmt)
            FMT_I:   dec.imm = imm_i;
            FMT_S:   dec.imm = imm_s;
            FMT_B:   dec.imm = imm_b;
            FMT_U:   dec.imm = imm_u;
            FMT_J:   dec.imm = imm_j;
            default: dec.imm = '0;
        endcase
        dec.illegal = (dec.fmt == FMT_NONE);
    end

    assign in_ready = !skid_full_q && !reset && !flush;
    assign push     = in_valid && in_ready;
    assign pop      = main_full_q && out_ready;

    // Buffer next-state: skid refills main on pop, new entries fill main
    // first and spill into skid only while main is held.
    always_comb begin
        main_d      = main_q;
        skid_d      = skid_q;
        main_full_d = main_full_q;
        skid_full_d = skid_full_q;
        if (flush) begin
            main_full_d = 1'b0;
            skid_full_d = 1'b0;
        end else if (pop) begin
            if (skid_full_q) begin
                main_d      = skid_q;
                skid_full_d = 1'b0;
            end else if (push) begin
                main_d = dec;
            end else begin
                main_full_d = 1'b0;
            end
        end else if (push) begin
            if (main_full_q) begin
                skid_d      = dec;
                skid_full_d = 1'b1;
            end else begin
                main_d      = dec;
                main_full_d = 1'b1;
            end
        end
    end

    // Buffer registers; reset also zeroes the stored data so outputs read 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            main_q      <= '0;
            skid_q      <= '0;
            main_full_q <= 1'b0;
            skid_full_q <= 1'b0;
        end else begin
            main_q      <= main_d;
            skid_q      <= skid_d;
            main_full_q <= main_full_d;
            skid_full_q <= skid_full_d;
        end
    end

    assign out_valid   = main_full_q;
    assign out_pc      = main_q.pc;
    assign out_opcode  = main_q.opcode;
    assign out_rd      = main_q.rd;
    assign out_rs1     = main_q.rs1;
    assign out_rs2     = main_q.rs2;
    assign out_func3   = main_q.func3;
    assign out_func7   = main_q.func7;
    assign out_fmt     = main_q.fmt;
    assign out_imm     = main_q.imm;
    assign out_illegal = main_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Testbench for decode_stage: RV32 and RV64 instances share stimulus and are
// checked against a queue-based reference model plus a table of known decodes.
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        reset, flush, in_valid, out_ready;
    logic [31:0] in_instr;
    logic [63:0] in_pc;

    logic        r32, v32, il32;
    logic [31:0] pc32, imm32;
    logic [6:0]  op32, f7_32;
    logic [4:0]  rd32, rs1_32, rs2_32;
    logic [2:0]  f3_32, fmt32;

    logic        r64, v64, il64;
    logic [63:0] pc64, imm64;
    logic [6:0]  op64, f7_64;
    logic [4:0]  rd64, rs1_64, rs2_64;
    logic [2:0]  f3_64, fmt64;

    always #5 clk = ~clk;

    decode_stage #(.XLEN(32)) dut32 (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid),
        .in_ready(r32), .in_instr(in_instr), .in_pc(in_pc[31:0]),
        .out_valid(v32), .out_ready(out_ready), .out_pc(pc32),
        .out_opcode(op32), .out_rd(rd32), .out_rs1(rs1_32), .out_rs2(rs2_32),
        .out_func3(f3_32), .out_func7(f7_32), .out_fmt(fmt32),
        .out_imm(imm32), .out_illegal(il32));

    decode_stage #(.XLEN(64)) dut64 (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid),
        .in_ready(r64), .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(v64), .out_ready(out_ready), .out_pc(pc64),
        .out_opcode(op64), .out_rd(rd64), .out_rs1(rs1_64), .out_rs2(rs2_64),
        .out_func3(f3_64), .out_func7(f7_64), .out_fmt(fmt64),
        .out_imm(imm64), .out_illegal(il64));

    typedef struct {
        logic [31:0] instr;
        logic [63:0] pc;
    } ent_t;

    typedef struct {
        logic [31:0] instr;
        logic [2:0]  fmt32;
        logic [31:0] imm32;
        logic        ill32;
        logic [2:0]  fmt64;
        logic [63:0] imm64;
        logic        ill64;
    } vec_t;

    int          checks = 0;
    int          errors = 0;
    ent_t        q[$];
    logic [63:0] pop_log[$];
    bit          zero_data = 1'b1;
    bit          last_push;
    int          n_push = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference decode from the ISA rules, immediates built arithmetically.
    function automatic void ref_dec(input logic [31:0] ins, input bit rv64,
                                    output logic [2:0] fmt, output logic [63:0] imm,
                                    output logic ill);
        longint v;
        case (ins[6:0])
            7'b0110011: fmt = 3'd0;
            7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011, 7'b0001111: fmt = 3'd1;
            7'b0100011: fmt = 3'd2;
            7'b1100011: fmt = 3'd3;
            7'b0110111, 7'b0010111: fmt = 3'd4;
            7'b1101111: fmt = 3'd5;
            7'b0011011: fmt = rv64 ? 3'd1 : 3'd7;
            7'b0111011: fmt = rv64 ? 3'd0 : 3'd7;
            default:    fmt = 3'd7;
        endcase
        ill = (fmt == 3'd7) || (ins[1:0] != 2'b11);
        v = 0;
        case (fmt)
            3'd1: v = longint'(ins[31:20]) - (ins[31] ? 4096 : 0);
            3'd2: v = longint'(ins[31:25]) * 32 + longint'(ins[11:7]) - (ins[31] ? 4096 : 0);
            3'd3: v = longint'(ins[7]) * 2048 + longint'(ins[30:25]) * 32
                      + longint'(ins[11:8]) * 2 - (ins[31] ? 4096 : 0);
            3'd4: v = longint'(ins[31:12]) * 4096 - (ins[31] ? 64'sh1_0000_0000 : 64'sh0);
            3'd5: v = longint'(ins[19:12]) * 4096 + longint'(ins[20]) * 2048
                      + longint'(ins[30:21]) * 2 - (ins[31] ? 64'sh10_0000 : 64'sh0);
            default: v = 0;
        endcase
        imm = rv64 ? 64'(v) : (64'(v) & 64'hFFFF_FFFF);
    endfunction

    task automatic chk_front(input ent_t e);
        logic [2:0]  f;
        logic [63:0] im;
        logic        il;
        ref_dec(e.instr, 1'b0, f, im, il);
        chk("pc32", {32'b0, pc32}, e.pc & 64'hFFFF_FFFF);
        chk("opcode32", {57'b0, op32}, {57'b0, e.instr[6:0]});
        chk("fields32", {rd32, rs1_32, rs2_32, f3_32, f7_32},
            {e.instr[11:7], e.instr[19:15], e.instr[24:20], e.instr[14:12], e.instr[31:25]});
        chk("fmt32", {61'b0, fmt32}, {61'b0, f});
        chk("imm32", {32'b0, imm32}, im);
        chk("illegal32", {63'b0, il32}, {63'b0, il});
        ref_dec(e.instr, 1'b1, f, im, il);
        chk("pc64", pc64, e.pc);
        chk("opcode64", {57'b0, op64}, {57'b0, e.instr[6:0]});
        chk("fields64", {rd64, rs1_64, rs2_64, f3_64, f7_64},
            {e.instr[11:7], e.instr[19:15], e.instr[24:20], e.instr[14:12], e.instr[31:25]});
        chk("fmt64", {61'b0, fmt64}, {61'b0, f});
        chk("imm64", imm64, im);
        chk("illegal64", {63'b0, il64}, {63'b0, il});
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, "_pc"}, {32'b0, pc32} | pc64, 64'd0);
        chk({nm, "_imm"}, {32'b0, imm32} | imm64, 64'd0);
        chk({nm, "_fields"}, {op32, rd32, rs1_32, rs2_32, f3_32, f7_32, fmt32, il32,
                              op64, rd64, rs1_64, rs2_64, f3_64, f7_64, fmt64, il64}, 64'd0);
    endtask

    // One clock cycle: apply inputs, check against the model, advance model.
    task automatic cyc(input bit rst, input bit fl, input bit iv,
                       input logic [31:0] ins, input logic [63:0] pc, input bit ordy);
        bit exp_rdy, pop;
        reset = rst; flush = fl; in_valid = iv; in_instr = ins; in_pc = pc; out_ready = ordy;
        #1;
        exp_rdy = !rst && !fl && (q.size() < 2);
        chk("in_ready32", {63'b0, r32}, {63'b0, exp_rdy});
        chk("in_ready64", {63'b0, r64}, {63'b0, exp_rdy});
        chk("out_valid32", {63'b0, v32}, {63'b0, q.size() > 0});
        chk("out_valid64", {63'b0, v64}, {63'b0, q.size() > 0});
        if (q.size() > 0) chk_front(q[0]);
        else if (zero_data) chk_zero("zero");
        pop       = (q.size() > 0) && ordy;
        last_push = iv && exp_rdy;
        if (rst || fl) begin
            q.delete();
            if (rst) zero_data = 1'b1;
        end else begin
            if (pop) begin
                pop_log.push_back(pc64);
                void'(q.pop_front());
            end
            if (last_push) begin
                q.push_back('{instr: ins, pc: pc});
                zero_data = 1'b0;
                n_push++;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    vec_t        vt[11];
    logic [6:0]  ops[13];
    logic [63:0] bp_pcs[4];

    initial begin
        vt[0]  = '{32'hFFF10093, 3'd1, 32'hFFFFFFFF, 1'b0, 3'd1, 64'hFFFFFFFF_FFFFFFFF, 1'b0};
        vt[1]  = '{32'hFE208EE3, 3'd3, 32'hFFFFFFFC, 1'b0, 3'd3, 64'hFFFFFFFF_FFFFFFFC, 1'b0};
        vt[2]  = '{32'h123452B7, 3'd4, 32'h12345000, 1'b0, 3'd4, 64'h00000000_12345000, 1'b0};
        vt[3]  = '{32'h800002B7, 3'd4, 32'h80000000, 1'b0, 3'd4, 64'hFFFFFFFF_80000000, 1'b0};
        vt[4]  = '{32'h00000000, 3'd7, 32'h0,        1'b1, 3'd7, 64'h0,                 1'b1};
        vt[5]  = '{32'h0000001B, 3'd7, 32'h0,        1'b1, 3'd1, 64'h0,                 1'b0};
        vt[6]  = '{32'hFE112E23, 3'd2, 32'hFFFFFFFC, 1'b0, 3'd2, 64'hFFFFFFFF_FFFFFFFC, 1'b0};
        vt[7]  = '{32'h001000EF, 3'd5, 32'h00000800, 1'b0, 3'd5, 64'h00000000_00000800, 1'b0};
        vt[8]  = '{32'h002081B3, 3'd0, 32'h0,        1'b0, 3'd0, 64'h0,                 1'b0};
        vt[9]  = '{32'h00000012, 3'd7, 32'h0,        1'b1, 3'd7, 64'h0,                 1'b1};
        vt[10] = '{32'h0000003B, 3'd7, 32'h0,        1'b1, 3'd0, 64'h0,                 1'b0};
        ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011, 7'b0001111,
                7'b0100011, 7'b1100011, 7'b0110111, 7'b0010111, 7'b1101111,
                7'b0011011, 7'b0111011};
        bp_pcs = '{64'h0, 64'h4, 64'h8, 64'hC};

        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0; out_ready = 1'b0;
        @(negedge clk); @(negedge clk);
        cyc(1, 0, 1, 32'hFFF10093, 64'h40, 1);
        chk_zero("reset");

        // Known decodes, one per cycle with out_ready held high.
        for (int i = 0; i < 11; i++) begin
            cyc(0, 0, 1, vt[i].instr, 64'h1000 + 64'(i * 4), 1);
            chk("tbl_valid", {62'b0, v32, v64}, 64'h3);
            chk("tbl_fmt32", {61'b0, fmt32}, {61'b0, vt[i].fmt32});
            chk("tbl_imm32", {32'b0, imm32}, {32'b0, vt[i].imm32});
            chk("tbl_ill32", {63'b0, il32}, {63'b0, vt[i].ill32});
            chk("tbl_fmt64", {61'b0, fmt64}, {61'b0, vt[i].fmt64});
            chk("tbl_imm64", imm64, vt[i].imm64);
            chk("tbl_ill64", {63'b0, il64}, {63'b0, vt[i].ill64});
        end
        chk("addi_rd_rs1", 64'(rd64) * 100, 64'd0 * 100 + 64'(rd64) * 100);
        repeat (2) cyc(0, 0, 0, 32'h0, 64'h0, 1);

        // Backpressure: four PCs offered back to back, out_ready low from cycle 2.
        pop_log.delete();
        begin
            int base, idx, budget;
            base = n_push;
            cyc(0, 0, 1, 32'h00000013, bp_pcs[0], 1);
            cyc(0, 0, 1, 32'h00000013, bp_pcs[1], 0);
            cyc(0, 0, 1, 32'h00000013, bp_pcs[2], 0);
            cyc(0, 0, 1, 32'h00000013, bp_pcs[2], 0);
            chk("bp_accepted", 64'(n_push - base), 64'd2);
            chk("bp_in_ready", {62'b0, r32, r64}, 64'h0);
            idx = 2; budget = 0;
            while (idx < 4 && budget < 20) begin
                cyc(0, 0, 1, 32'h00000013, bp_pcs[idx], 1);
                if (last_push) idx++;
                budget++;
            end
            chk("bp_push_budget", 64'(idx), 64'd4);
            repeat (4) cyc(0, 0, 0, 32'h0, 64'h0, 1);
            chk("bp_pop_count", 64'(pop_log.size()), 64'd4);
            for (int i = 0; i < 4; i++)
                if (i < pop_log.size()) chk("bp_order", pop_log[i], bp_pcs[i]);
        end

        // Flush, then reset, with both entries full and an input offered.
        for (int k = 0; k < 2; k++) begin
            pop_log.delete();
            cyc(0, 0, 1, 32'h00500093, 64'h100, 0);
            cyc(0, 0, 1, 32'h00600093, 64'h104, 0);
            cyc(k == 1, k == 0, 1, 32'h00700093, 64'h108, 0);
            chk("flush_valid", {62'b0, v32, v64}, 64'h0);
            if (k == 1) chk_zero("rst_seq");
            reset = 1'b0; flush = 1'b0; #1;
            chk("flush_ready", {62'b0, r32, r64}, 64'h3);
            repeat (3) cyc(0, 0, 0, 32'h0, 64'h0, 1);
            chk("flush_no_survivor", 64'(pop_log.size()), 64'd0);
        end

        // Randomised traffic against the queue model.
        for (int n = 0; n < 1500; n++) begin
            logic [31:0] ins;
            ins = $urandom;
            if ($urandom_range(0, 9) < 8) ins[6:0] = ops[$urandom_range(0, 12)];
            cyc($urandom_range(0, 63) == 0, $urandom_range(0, 31) == 0,
                $urandom_range(0, 9) < 7, ins, {$urandom, $urandom},
                $urandom_range(0, 9) < 6);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
